// File: rtl/jump_pkg.sv
// Shared definitions between jump_motion and the game state machine:
// state encoding, playfield geometry and default motion constants.
package jump_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_RELD = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACCU = 3'd3,
    ST_JUMP = 3'd4,
    ST_LAND = 3'd5,
    ST_OVER = 3'd6
  } game_state_e;

  localparam int unsigned BLOCK_WIDTH     = 20;
  localparam int unsigned ORIGIN          = 0;
  localparam int unsigned DEF_GAP_MIN     = 40;
  localparam int unsigned DEF_SPEED       = 4;
  localparam int unsigned DEF_RELOAD_STEP = 4;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/jump_motion_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that randomises the block gap.
// Advances once per enabled cycle; reset reloads the seed.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_machine,
  input  logic       rst_machine,
  input  logic       en,
  output logic [7:0] q
);

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/jump_motion.sv
// Charge, jump, next-block and scroll-back datapath driven by the game state.
// All outputs are registered; motion advances only on frame ticks.
module jump_motion
  import jump_pkg::*;
#(
  parameter int unsigned CHARGE_W    = 8,
  parameter int unsigned CHARGE_MAX  = 200,
  parameter int unsigned SPEED       = DEF_SPEED,
  parameter int unsigned RELOAD_STEP = DEF_RELOAD_STEP,
  parameter int unsigned GAP_MIN     = DEF_GAP_MIN,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                clk_machine,
  input  logic                rst_machine,
  input  logic                i_tick,
  input  logic                i_btn,
  input  logic [2:0]          state,
  output logic                o_jump_done,
  output logic [31:0]         o_x_man,
  output logic [31:0]         o_x_block1,
  output logic [31:0]         o_x_block2,
  output logic                reload_done,
  output logic [CHARGE_W-1:0] o_charge
);

  logic [CHARGE_W-1:0] remain;
  logic [7:0]          lfsr;
  logic [1:0]          unused_lfsr_hi;
  logic                lfsr_en;
  logic [31:0]         jump_step;
  logic [31:0]         reload_step;
  logic [31:0]         gap;

  function automatic logic [CHARGE_W-1:0] charge_inc(input logic [CHARGE_W-1:0] c);
    return (c >= CHARGE_W'(CHARGE_MAX)) ? CHARGE_W'(CHARGE_MAX) : c + CHARGE_W'(1);
  endfunction

  function automatic logic [31:0] sub_sat0(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : 32'd0;
  endfunction

  // The gap uses the LFSR value from before this INIT cycle's advance.
  assign lfsr_en        = (state == ST_INIT);
  assign unused_lfsr_hi = lfsr[7:6];
  assign gap            = 32'(GAP_MIN) + {26'd0, lfsr[5:0]};
  assign jump_step      = min_u32(32'(SPEED), 32'(remain));
  assign reload_step    = min_u32(32'(RELOAD_STEP), o_x_block1);

  lfsr8 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_machine(clk_machine),
    .rst_machine(rst_machine),
    .en         (lfsr_en),
    .q          (lfsr)
  );

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      o_x_man     <= 32'd0;
      o_x_block1  <= 32'd0;
      o_x_block2  <= 32'(GAP_MIN);
      o_charge    <= '0;
      remain      <= '0;
      o_jump_done <= 1'b0;
      reload_done <= 1'b0;
    end else begin
      o_jump_done <= 1'b0;
      reload_done <= 1'b0;
      case (state)
        ST_WAIT: begin
          o_charge <= '0;
          remain   <= '0;
        end
        ST_ACCU: begin
          // Release wins over a coincident tick; zero charge is a legal jump.
          if (!i_btn) begin
            remain      <= o_charge;
            o_jump_done <= 1'b1;
          end else if (i_tick) begin
            o_charge <= charge_inc(o_charge);
          end
        end
        ST_JUMP: begin
          if (i_tick) begin
            if (remain != '0) begin
              o_x_man <= o_x_man + jump_step;
              remain  <= remain - CHARGE_W'(jump_step);
            end else begin
              o_jump_done <= 1'b1;
              o_charge    <= '0;
            end
          end
        end
        ST_INIT: begin
          o_x_block1 <= o_x_block2;
          o_x_block2 <= o_x_block2 + gap;
        end
        ST_RELD: begin
          if (o_x_block1 == 32'd0) begin
            reload_done <= 1'b1;
          end else if (i_tick) begin
            o_x_block1 <= o_x_block1 - reload_step;
            o_x_block2 <= o_x_block2 - reload_step;
            o_x_man    <= sub_sat0(o_x_man, reload_step);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_motion.sv
// Directed bench for jump_motion: expected outputs are queued per driven
// cycle and checked against the DUT one time unit after the clock edge.
module tb_jump_motion;

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_RELD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ACCU = 3'd3;
  localparam logic [2:0] S_JUMP = 3'd4;
  localparam logic [2:0] S_LAND = 3'd5;
  localparam logic [2:0] S_OVER = 3'd6;

  logic        clk_machine = 1'b0;
  logic        rst_machine;
  logic        i_tick;
  logic        i_btn;
  logic [2:0]  state;
  logic        o_jump_done;
  logic [31:0] o_x_man;
  logic [31:0] o_x_block1;
  logic [31:0] o_x_block2;
  logic        reload_done;
  logic [7:0]  o_charge;

  jump_motion dut (
    .clk_machine(clk_machine),
    .rst_machine(rst_machine),
    .i_tick     (i_tick),
    .i_btn      (i_btn),
    .state      (state),
    .o_jump_done(o_jump_done),
    .o_x_man    (o_x_man),
    .o_x_block1 (o_x_block1),
    .o_x_block2 (o_x_block2),
    .reload_done(reload_done),
    .o_charge   (o_charge)
  );

  always #5 clk_machine = ~clk_machine;

  typedef struct {
    string       tag;
    logic [31:0] man;
    logic [31:0] b1;
    logic [31:0] b2;
    logic [31:0] chg;
    logic        jd;
    logic        rd;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] ex_man, ex_b1, ex_b2, ex_chg;
  logic        ex_jd, ex_rd;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.man = ex_man;
    e.b1  = ex_b1;
    e.b2  = ex_b2;
    e.chg = ex_chg;
    e.jd  = ex_jd;
    e.rd  = ex_rd;
    exp_q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL queue observed=empty expected=entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.tag, "man",    o_x_man,          e.man);
      chk(e.tag, "block1", o_x_block1,       e.b1);
      chk(e.tag, "block2", o_x_block2,       e.b2);
      chk(e.tag, "charge", 32'(o_charge),    e.chg);
      chk(e.tag, "jdone",  32'(o_jump_done), 32'(e.jd));
      chk(e.tag, "rdone",  32'(reload_done), 32'(e.rd));
    end
    ex_jd = 1'b0;
    ex_rd = 1'b0;
  endtask

  // One clock: drive inputs, queue what the outputs must be after the edge.
  task automatic go(input string tag, input logic [2:0] st, input logic btn, input logic tk);
    state  = st;
    i_btn  = btn;
    i_tick = tk;
    push_exp(tag);
    @(posedge clk_machine);
    #1;
    pop_compare();
  endtask

  task automatic expect_reset_values();
    ex_man = 0; ex_b1 = 0; ex_b2 = 40; ex_chg = 0; ex_jd = 0; ex_rd = 0;
  endtask

  initial begin
    int rem;
    rst_machine = 1'b1;
    state  = S_WAIT;
    i_btn  = 1'b0;
    i_tick = 1'b0;
    expect_reset_values();
    #3;
    push_exp("reset");
    pop_compare();
    @(posedge clk_machine);
    #1;
    rst_machine = 1'b0;

    go("wait_hold", S_WAIT, 1'b0, 1'b1);
    ex_rd = 1'b1;
    go("reld_first", S_RELD, 1'b0, 1'b0);
    go("reld_once", S_WAIT, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ex_chg = i + 1;
      go("accu10", S_ACCU, 1'b1, 1'b1);
      go("accu10_notick", S_ACCU, 1'b1, 1'b0);
    end
    ex_jd = 1'b1;
    go("release10", S_ACCU, 1'b0, 1'b0);

    go("jump_notick", S_JUMP, 1'b0, 1'b0);
    ex_man = 4;
    go("jump_t1", S_JUMP, 1'b0, 1'b1);
    go("jump_btn_ign", S_JUMP, 1'b1, 1'b0);
    ex_man = 8;
    go("jump_t2", S_JUMP, 1'b1, 1'b1);
    ex_man = 10;
    go("jump_t3", S_JUMP, 1'b0, 1'b1);
    ex_jd = 1'b1; ex_chg = 0;
    go("jump_done", S_JUMP, 1'b0, 1'b1);
    go("land_hold", S_LAND, 1'b0, 1'b1);
    go("wait2", S_WAIT, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ex_chg = i + 1;
      go("accu30", S_ACCU, 1'b1, 1'b1);
    end
    ex_jd = 1'b1;
    go("release30", S_ACCU, 1'b0, 1'b1);
    rem = 30;
    while (rem > 0) begin
      ex_man = ex_man + ((rem > 4) ? 4 : rem);
      rem    = rem - ((rem > 4) ? 4 : rem);
      go("jump30", S_JUMP, 1'b0, 1'b1);
    end
    ex_jd = 1'b1; ex_chg = 0;
    go("jump30_done", S_JUMP, 1'b0, 1'b1);
    go("wait3", S_WAIT, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ex_chg = (i + 1 > 200) ? 200 : i + 1;
      go("accu_sat", S_ACCU, 1'b1, 1'b1);
    end
    ex_chg = 0;
    go("wait_clear", S_WAIT, 1'b1, 1'b0);

    ex_b1 = 40; ex_b2 = 117;
    go("init", S_INIT, 1'b0, 1'b0);
    go("reld_notick", S_RELD, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ex_b1  = ex_b1 - 4;
      ex_b2  = ex_b2 - 4;
      ex_man = ex_man - 4;
      go("reld_scroll", S_RELD, 1'b0, 1'b1);
    end
    ex_rd = 1'b1;
    go("reld_done", S_RELD, 1'b0, 1'b1);
    go("after_reld", S_WAIT, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      go("over_frozen", S_OVER, i[0], 1'b1);
    end
    go("state7_hold", 3'd7, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      ex_chg = i + 1;
      go("accu5", S_ACCU, 1'b1, 1'b1);
    end
    ex_jd = 1'b1;
    go("release5", S_ACCU, 1'b0, 1'b0);
    ex_man = 4;
    go("jump5_t1", S_JUMP, 1'b0, 1'b1);

    // Mid-cycle reset: outputs must clear before any clock edge.
    #2;
    rst_machine = 1'b1;
    #1;
    expect_reset_values();
    push_exp("async_reset");
    pop_compare();
    #1;
    rst_machine = 1'b0;
    ex_b1 = 40; ex_b2 = 117;
    go("init_reseeded", S_INIT, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
